// File: rtl/fir_filter_pipe.sv
// fir_filter_pipe: signed N-tap FIR with run-time programmable coefficients, fixed-point
// rounding and a 2-stage elastic (valid/ready) pipeline.
//
// Ports:
//   clk_i        clock, rising edge
//   reset_ni     asynchronous active-low reset
//   flush_i      synchronous clear of sample history and pipeline (coefficients kept)
//   coef_we_i    coefficient write strobe
//   coef_addr_i  tap index to write (writes to indices >= taps_p are ignored)
//   coef_data_i  signed coefficient value
//   data_i       input sample (signed)
//   valid_i      input valid
//   ready_o      input ready
//   valid_o      output valid
//   data_o       filtered output sample (signed)
//   ready_i      output ready
//
// Build option: define FILTER_SAT_EN to clamp out-of-range results to the nearest
// representable bound; by default the low width_p bits are kept (two's complement wrap).
module fir_filter_pipe #(
    parameter int unsigned width_p      = 24,
    parameter int unsigned taps_p       = 7,
    parameter int unsigned coef_width_p = 8,
    parameter int unsigned frac_p       = 3
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic                      flush_i,
    input  logic                      coef_we_i,
    input  logic [$clog2(taps_p)-1:0] coef_addr_i,
    input  logic [coef_width_p-1:0]   coef_data_i,
    input  logic [width_p-1:0]        data_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic                      valid_o,
    output logic [width_p-1:0]        data_o,
    input  logic                      ready_i
);

    localparam int unsigned ProdW = width_p + coef_width_p;
    // Headroom for summing taps_p products without overflow.
    localparam int unsigned SumW  = ProdW + $clog2(taps_p) + 1;
    localparam int unsigned CntW  = $clog2(taps_p + 1);

    typedef logic signed [width_p-1:0]      sample_t;
    typedef logic signed [coef_width_p-1:0] coef_t;
    typedef logic signed [ProdW-1:0]        prod_t;
    typedef logic signed [SumW-1:0]         sum_t;

    localparam coef_t CoefUnity = coef_t'(1 << frac_p);
    localparam sum_t  RoundC    = (frac_p == 0) ? sum_t'(0)
                                                : (sum_t'(1) <<< (frac_p > 0 ? frac_p - 1 : 0));

    sample_t         win_q   [taps_p];
    sample_t         win_d   [taps_p];
    coef_t           coef_q  [taps_p];
    coef_t           coef_d  [taps_p];
    prod_t           prod_q  [taps_p];
    prod_t           prod_d  [taps_p];
    logic [CntW-1:0] fill_q, fill_d;
    logic            s1_v_q, s1_v_d;
    logic            valid_q, valid_d;
    sample_t         data_q, data_d;

    logic            s2_adv, s1_adv, accept, s1_load;
    sum_t            sum, shifted;
    sample_t         result;

    // Elastic handshake: a stage may advance when its downstream slot is free or draining.
    assign s2_adv  = ~valid_q | ready_i;
    assign s1_adv  = ~s1_v_q | s2_adv;
    assign ready_o = s1_adv & ~flush_i;
    assign accept  = valid_i & ready_o;

    assign valid_o = valid_q;
    assign data_o  = data_q;

    // Sample window and fill count.
    always_comb begin
        win_d  = win_q;
        fill_d = fill_q;
        if (flush_i) begin
            for (int k = 0; k < int'(taps_p); k++) begin
                win_d[k] = '0;
            end
            fill_d = '0;
        end else if (accept) begin
            win_d[0] = sample_t'(data_i);
            for (int k = 1; k < int'(taps_p); k++) begin
                win_d[k] = win_q[k-1];
            end
            if (fill_q != CntW'(taps_p)) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    // Only an accept that completes (or keeps) a full window produces a result.
    assign s1_load = accept & (fill_d == CntW'(taps_p));

    // Coefficient bank; a write lands at the edge, so products formed in the same
    // cycle still use the old value.
    always_comb begin
        coef_d = coef_q;
        if (coef_we_i && (int'(coef_addr_i) < int'(taps_p))) begin
            coef_d[coef_addr_i] = coef_t'(coef_data_i);
        end
    end

    // Stage 1: per-tap products from the post-shift window.
    always_comb begin
        s1_v_d = s1_v_q;
        prod_d = prod_q;
        if (flush_i) begin
            s1_v_d = 1'b0;
        end else if (s1_adv) begin
            s1_v_d = s1_load;
            if (s1_load) begin
                for (int k = 0; k < int'(taps_p); k++) begin
                    prod_d[k] = prod_t'(coef_q[k]) * prod_t'(win_d[k]);
                end
            end
        end
    end

    // Stage 2 datapath: sum, round half-up, arithmetic shift, reduce to width_p.
    always_comb begin
        sum = '0;
        for (int k = 0; k < int'(taps_p); k++) begin
            sum = sum + sum_t'(prod_q[k]);
        end
        sum     = sum + RoundC;
        shifted = sum >>> frac_p;
`ifdef FILTER_SAT_EN
        // In range only if every bit above the output sign bit matches it.
        if ((shifted[SumW-1:width_p-1] != '0) && (shifted[SumW-1:width_p-1] != '1)) begin
            result = shifted[SumW-1] ? {1'b1, {(width_p-1){1'b0}}}
                                     : {1'b0, {(width_p-1){1'b1}}};
        end else begin
            result = sample_t'(shifted);
        end
`else
        result = sample_t'(shifted);
`endif
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (s2_adv) begin
            valid_d = s1_v_q;
            if (s1_v_q) begin
                data_d = result;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int k = 0; k < int'(taps_p); k++) begin
                win_q[k]  <= '0;
                prod_q[k] <= '0;
                coef_q[k] <= (k == 0) ? CoefUnity : coef_t'(0);
            end
            fill_q  <= '0;
            s1_v_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            win_q   <= win_d;
            prod_q  <= prod_d;
            coef_q  <= coef_d;
            fill_q  <= fill_d;
            s1_v_q  <= s1_v_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_fir_filter_pipe.sv
// tb_fir_filter_pipe: scoreboard bench for fir_filter_pipe (default parameters).
// Expected outputs are hand-computed constants pushed when the driver's sample is accepted;
// a monitor process pops and compares on every output handshake and checks that a stalled
// output holds steady.
module tb_fir_filter_pipe;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        flush_i;
    logic        coef_we_i;
    logic [2:0]  coef_addr_i;
    logic [7:0]  coef_data_i;
    logic [23:0] data_i;
    logic        valid_i;
    logic        ready_o;
    logic        valid_o;
    logic [23:0] data_o;
    logic        ready_i;

    fir_filter_pipe dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .flush_i     (flush_i),
        .coef_we_i   (coef_we_i),
        .coef_addr_i (coef_addr_i),
        .coef_data_i (coef_data_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .valid_o     (valid_o),
        .data_o      (data_o),
        .ready_i     (ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [23:0] data;
        int          cyc;   // cycle the accept was presented, or -1 if latency not checked
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic        held_v;
    logic [23:0] held_d;

`ifdef FILTER_SAT_EN
    localparam logic [23:0] OvfPos = 24'h7FFFFF;
    localparam logic [23:0] OvfNeg = 24'h800000;
`else
    localparam logic [23:0] OvfPos = 24'h8FFF91;
    localparam logic [23:0] OvfNeg = 24'h700000;
`endif

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endfunction

    // Monitor: compare on each output handshake; a stalled output must not change.
    initial begin
        exp_t e;
        held_v = 1'b0;
        held_d = '0;
        forever begin
            @(negedge clk_i);
            if (!reset_ni) begin
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    check("hold_valid", {31'b0, valid_o}, 32'd1);
                    check("hold_data", {8'b0, data_o}, {8'b0, held_d});
                end
                held_v = 1'b0;
                if (valid_o && ready_i) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got %h, required no output", data_o);
                    end else begin
                        e = sb.pop_front();
                        check("output_data", {8'b0, data_o}, {8'b0, e.data});
                        if (e.cyc >= 0) check("latency", 32'(cyc - e.cyc), 32'd2);
                    end
                end else if (valid_o && !flush_i) begin
                    held_v = 1'b1;
                    held_d = data_o;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Present one sample; push its expected result when the accept is seen.
    task automatic send(input logic [23:0] d, input bit has_exp, input logic [23:0] e,
                        input bit lat);
        int   n;
        exp_t item;
        valid_i = 1'b1;
        data_i  = d;
        n       = 0;
        @(negedge clk_i);
        while (!ready_o && n < 200) begin
            n++;
            @(negedge clk_i);
        end
        if (!ready_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got ready_o=0, required 1");
        end else if (has_exp) begin
            item.data = e;
            item.cyc  = lat ? cyc : -1;
            sb.push_back(item);
        end
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic write_coef(input logic [2:0] a, input logic [7:0] v);
        coef_we_i   = 1'b1;
        coef_addr_i = a;
        coef_data_i = v;
        @(posedge clk_i);
        #1;
        coef_we_i   = 1'b0;
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk_i);
        while ((sb.size() != 0 || valid_o) && n < 100) begin
            n++;
            @(negedge clk_i);
        end
        check("drain_empty", {31'b0, (sb.size() == 0) && !valid_o}, 32'd1);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_ni    = 1'b0;
        flush_i     = 1'b0;
        coef_we_i   = 1'b0;
        coef_addr_i = '0;
        coef_data_i = '0;
        data_i      = '0;
        valid_i     = 1'b0;
        ready_i     = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_valid_o", {31'b0, valid_o}, 32'd0);
        check("reset_data_o", {8'b0, data_o}, 32'd0);
        reset_ni = 1'b1;
        #1;
        check("reset_ready_o", {31'b0, ready_o}, 32'd1);
        @(posedge clk_i);
        #1;

        // Passthrough with default coefficients: only samples 7..10 produce output.
        for (int i = 1; i <= 10; i++) send(24'(i), i >= 7, 24'(i), 1'b1);
        drain();

        // Out-of-range coefficient address must change nothing.
        write_coef(3'd7, 8'd50);
        send(24'd11, 1'b1, 24'd11, 1'b1);
        drain();

        // Averaging: all coefs 8 (unity), constant 100.
        for (int k = 0; k < 7; k++) write_coef(3'(k), 8'd8);
        do_flush();
        for (int i = 1; i <= 7; i++) send(24'd100, i == 7, 24'd700, 1'b1);
        drain();
        ready_i = 1'b0;
        send(24'd100, 1'b1, 24'd700, 1'b0);
        send(24'd100, 1'b1, 24'd700, 1'b0);
        write_coef(3'd3, 8'hF8);          // -8 while two 700s are in flight
        ready_i = 1'b1;
        send(24'd100, 1'b1, 24'd500, 1'b0);
        // Write together with an accept: this accept still sees -8.
        coef_we_i   = 1'b1;
        coef_addr_i = 3'd3;
        coef_data_i = 8'd8;
        send(24'd100, 1'b1, 24'd500, 1'b0);
        coef_we_i   = 1'b0;
        send(24'd100, 1'b1, 24'd700, 1'b0);
        drain();

        // Backpressure: passthrough, 20 samples, ready_i low for 5 cycles.
        write_coef(3'd0, 8'd8);
        for (int k = 1; k < 7; k++) write_coef(3'(k), 8'd0);
        do_flush();
        fork
            begin
                for (int i = 1; i <= 20; i++) send(24'(i), i >= 7, 24'(i), 1'b0);
            end
            begin
                repeat (9) @(posedge clk_i);
                #1;
                ready_i = 1'b0;
                @(negedge clk_i);
                check("bp_ready_low", {31'b0, ready_o}, 32'd0);
                repeat (5) @(posedge clk_i);
                #1;
                ready_i = 1'b1;
            end
        join
        drain();

        // Overflow: all coefs 127 with full-scale inputs.
        for (int k = 0; k < 7; k++) write_coef(3'(k), 8'd127);
        do_flush();
        for (int i = 1; i <= 7; i++) send(24'h7FFFFF, i == 7, OvfPos, 1'b1);
        drain();
        do_flush();
        for (int i = 1; i <= 7; i++) send(24'h800000, i == 7, OvfNeg, 1'b1);
        drain();

        // Flush: coef0=coef1=8 gives x[0]+x[1].
        write_coef(3'd0, 8'd8);
        write_coef(3'd1, 8'd8);
        for (int k = 2; k < 7; k++) write_coef(3'(k), 8'd0);
        do_flush();
        for (int i = 1; i <= 8; i++) send(24'(i), i >= 7, 24'(2 * i - 1), 1'b1);
        drain();
        ready_i = 1'b0;
        send(24'd9, 1'b1, 24'd17, 1'b0);
        send(24'd10, 1'b1, 24'd19, 1'b0);
        flush_i = 1'b1;
        valid_i = 1'b1;
        data_i  = 24'd99;
        @(negedge clk_i);
        check("flush_ready_o", {31'b0, ready_o}, 32'd0);
        @(posedge clk_i);
        #1;
        check("flush_valid_o", {31'b0, valid_o}, 32'd0);
        flush_i = 1'b0;
        valid_i = 1'b0;
        sb.delete();                      // in-flight results are discarded by the flush
        ready_i = 1'b1;
        for (int i = 1; i <= 7; i++) send(24'(i), i == 7, 24'd13, 1'b1);
        drain();

        // Async reset while an output is stalled.
        ready_i = 1'b0;
        send(24'd20, 1'b1, 24'd27, 1'b0);
        @(posedge clk_i);
        #2;
        check("pre_reset_valid", {31'b0, valid_o}, 32'd1);
        reset_ni = 1'b0;
        #1;
        check("async_valid_o", {31'b0, valid_o}, 32'd0);
        check("async_data_o", {8'b0, data_o}, 32'd0);
        sb.delete();
        ready_i = 1'b1;
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        #1;
        check("post_reset_ready", {31'b0, ready_o}, 32'd1);
        for (int i = 1; i <= 7; i++) send(24'(i), i == 7, 24'd7, 1'b1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
